// File: rtl/dice_game_ctrl.sv
// Two-player turn scheduler for a shared electronic dice.
// Handles roll requests from the player whose turn it is and holds the dice
// button for a bounded window. After the button falls it waits for the face
// to settle, then samples it and adds it to that player's score.
// Every output comes straight from a flop. Each output register is loaded
// from the next-state / next-value logic, so it describes the state the FSM
// is entering on that edge.
module dice_game_ctrl #(
  parameter int ROLL_MIN = 8,
  parameter int SETTLE   = 2,
  parameter int TARGET   = 20,
  parameter int SCORE_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_reset,
  input  logic               req_a,
  input  logic               req_b,
  input  logic [2:0]         throw,
  output logic               dice_button,
  output logic               turn,
  output logic               busy,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [2:0]         last_throw,
  output logic               result_valid,
  output logic               winner_valid,
  output logic               winner
);

  localparam int RC_W = (ROLL_MIN > 1) ? $clog2(ROLL_MIN) : 1;
  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [RC_W-1:0]    ROLL_LAST   = RC_W'(ROLL_MIN - 1);
  localparam logic [SC_W-1:0]    SETTLE_LAST = SC_W'(SETTLE - 1);
  localparam logic [SCORE_W-1:0] TGT         = SCORE_W'(TARGET);

  typedef enum logic [2:0] {
    S_IDLE, S_ROLL, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  state_t state, state_n;

  logic [RC_W-1:0]    roll_cnt, roll_cnt_n;
  logic [SC_W-1:0]    settle_cnt, settle_cnt_n;
  logic [SCORE_W-1:0] score_a_n, score_b_n;
  logic [2:0]         last_throw_n;
  logic               turn_n, winner_n, result_valid_n;

  // Helper terms for the current player
  logic               cur_req;
  logic               face_ok;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] clamped;

  // Current player's request, face validity and clamped score sum
  always_comb begin
    cur_req   = turn ? req_b : req_a;
    face_ok   = (throw != 3'd0) && (throw != 3'd7);
    cur_score = turn ? score_b : score_a;
    // One extra bit so the sum cannot wrap before it is clamped
    sum       = (SCORE_W+1)'(cur_score) + (SCORE_W+1)'(throw);
    clamped   = (sum >= (SCORE_W+1)'(TARGET)) ? TGT : sum[SCORE_W-1:0];
  end

  // Next-state and next-value logic; game_reset overrides everything
  always_comb begin
    state_n        = state;
    roll_cnt_n     = roll_cnt;
    settle_cnt_n   = settle_cnt;
    score_a_n      = score_a;
    score_b_n      = score_b;
    last_throw_n   = last_throw;
    turn_n         = turn;
    winner_n       = winner;
    result_valid_n = 1'b0;

    case (state)
      S_IDLE: begin
        // Only the current player's request counts; the other is not queued
        if (cur_req) begin
          state_n    = S_ROLL;
          roll_cnt_n = '0;
        end
      end
      S_ROLL: begin
        // Hold the button for at least ROLL_MIN cycles. Keep holding it while
        // the player holds the request.
        if ((roll_cnt >= ROLL_LAST) && !cur_req) begin
          state_n      = S_SETTLE;
          settle_cnt_n = '0;
        end else if (roll_cnt < ROLL_LAST) begin
          // Saturate: only the ROLL_MIN-1 threshold matters
          roll_cnt_n = roll_cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_n = S_SAMPLE;
        else settle_cnt_n = settle_cnt + 1'b1;
      end
      S_SAMPLE: begin
        if (face_ok) begin
          if (turn) score_b_n = clamped;
          else      score_a_n = clamped;
          last_throw_n   = throw;
          result_valid_n = 1'b1;
          if (clamped == TGT) begin
            state_n  = S_DONE;
            winner_n = turn;
          end else begin
            state_n = S_IDLE;
            turn_n  = ~turn;
          end
        end else begin
          // A bad face triggers a re-roll for the same player with no request
          state_n    = S_ROLL;
          roll_cnt_n = '0;
        end
      end
      S_DONE: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    if (game_reset) begin
      state_n        = S_IDLE;
      roll_cnt_n     = '0;
      settle_cnt_n   = '0;
      score_a_n      = '0;
      score_b_n      = '0;
      last_throw_n   = '0;
      turn_n         = 1'b0;
      winner_n       = 1'b0;
      result_valid_n = 1'b0;
    end
  end

  // State, counters and scoring registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      roll_cnt     <= '0;
      settle_cnt   <= '0;
      score_a      <= '0;
      score_b      <= '0;
      last_throw   <= '0;
      turn         <= 1'b0;
      winner       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      roll_cnt     <= roll_cnt_n;
      settle_cnt   <= settle_cnt_n;
      score_a      <= score_a_n;
      score_b      <= score_b_n;
      last_throw   <= last_throw_n;
      turn         <= turn_n;
      winner       <= winner_n;
      result_valid <= result_valid_n;
    end
  end

  // State-decoded outputs, registered from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dice_button  <= 1'b0;
      busy         <= 1'b0;
      winner_valid <= 1'b0;
    end else begin
      dice_button  <= (state_n == S_ROLL);
      busy         <= (state_n == S_ROLL) || (state_n == S_SETTLE) ||
                      (state_n == S_SAMPLE);
      winner_valid <= (state_n == S_DONE);
    end
  end

endmodule
